// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line-level constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1 while enabled and flags the last cycle of each bit.
module fifo_uart_tx_baud_counter #(
    parameter int CYCLES_PER_BIT = 10,
    parameter int TW             = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_done_o
);

    logic [TW-1:0] count_q, count_d;

    assign bit_done_o = en_i && (count_q == TW'(CYCLES_PER_BIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = bit_done_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops one word per frame from a first-word-fall-through FIFO.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BIT_RATE     = 115_200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    output logic                    fifo_read,
    input  logic [PAYLOAD_BITS-1:0] fifo_read_data,
    output logic                    tx,
    output logic                    busy,
    output tx_state_t               dbg_state
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int TW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    generate
        if (CYCLES_PER_BIT < 2) begin : g_bad_rate
            $error("fifo_uart_tx: CLK_FREQ/BIT_RATE must be at least 2");
        end
    endgenerate

    tx_state_t               state_q;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]           bit_idx_q;
    logic                    tx_q, busy_q, read_q;
    logic                    bit_done;

    fifo_uart_tx_baud_counter #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT),
        .TW            (TW)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE),
        .en_i      (state_q != IDLE),
        .bit_done_o(bit_done)
    );

    assign shift_d = shift_q >> 1;

    // FIFO handshake: the head word is valid whenever fifo_empty is low; it is
    // captured at the same edge that schedules the pop, and fifo_read is a
    // one-cycle pulse so the FIFO advances at the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            read_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_read_data;
                        read_q  <= 1'b1;
                        tx_q    <= START_BIT;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == BW'(PAYLOAD_BITS - 1)) begin
                            tx_q    <= LINE_IDLE;
                            state_q <= STOP;
                        end else begin
                            tx_q <= shift_d[0];
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_read = read_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx at 10 clocks per bit: a FIFO model feeds the DUT, a UART decoder checks frames.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         fifo_empty = 1'b1;
    logic         fifo_read;
    logic [W-1:0] fifo_read_data = '0;
    logic         tx, busy;
    tx_state_t    dbg_state;

    fifo_uart_tx #(
        .CLK_FREQ    (1_000_000),
        .BIT_RATE    (100_000),
        .PAYLOAD_BITS(W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_read     (fifo_read),
        .fifo_read_data(fifo_read_data),
        .tx            (tx),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, pushed = 0, reads = 0;
    int rd_cyc[$], st_cyc[$];
    bit scramble = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag_fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endfunction

    task automatic push(input logic [W-1:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0 || busy) && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        if (k >= max_cycles) flag_fail("drain_timeout");
        repeat (5) @(negedge clk);
    endtask

    // FIFO model: pops on the edge after fifo_read is seen high
    initial begin : fifo_driver
        bit pop_pending;
        forever begin
            @(negedge clk);
            pop_pending = fifo_read;
            @(posedge clk);
            #1;
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_empty = (fifo_q.size() == 0);
            if (scramble && busy) fifo_read_data = W'($urandom);
            else fifo_read_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // monitor: pop pulses, busy run length, UART decoding against exp_q
    bit           prev_read = 0, dec_active = 0, run_abort = 0;
    int           dec_cnt = 0, run = 0;
    logic [W-1:0] dec_byte = '0;

    always @(negedge clk) begin
        cyc++;
        if (fifo_read === 1'b1) begin
            reads++;
            rd_cyc.push_back(cyc);
            check("read_pulse_width", 32'(prev_read), 0);
            check("frame_start_busy_tx", {busy, tx}, 2'b10);
        end
        prev_read = (fifo_read === 1'b1);

        if (reset) run_abort = 1;
        if (busy === 1'b1) run++;
        else if (run > 0) begin
            if (!run_abort) check("busy_len", run, 100);
            run = 0;
            run_abort = 0;
        end

        if (reset) dec_active = 0;
        else if (!dec_active) begin
            if (tx === 1'b0) begin
                dec_active = 1;
                dec_cnt = 0;
                st_cyc.push_back(cyc);
            end
        end else dec_cnt++;

        if (dec_active) begin
            if (dec_cnt == 5) check("start_bit", 32'(tx), 0);
            else if (dec_cnt >= 15 && dec_cnt <= 85 && dec_cnt % 10 == 5)
                dec_byte[(dec_cnt - 15) / 10] = tx;
            else if (dec_cnt == 95) begin
                check("stop_bit", 32'(tx), 1);
                if (exp_q.size() == 0) flag_fail("unexpected_frame");
                else check("byte", dec_byte, exp_q.pop_front());
                dec_active = 0;
            end
        end
    end

    initial begin : stimulus
        int bad, n0, k;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_read", 32'(fifo_read), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // empty FIFO holds the line idle
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) bad++;
        end
        check("empty_idle_violations", bad, 0);

        // single byte
        n0 = reads;
        push(8'hA5);
        wait_drain(300);
        check("single_pops", reads - n0, 1);

        // back-to-back 0x00, 0xFF
        rd_cyc.delete();
        st_cyc.delete();
        push(8'h00);
        push(8'hFF);
        wait_drain(400);
        check("b2b_pops", rd_cyc.size(), 2);
        if (rd_cyc.size() >= 2) check("pop_spacing", rd_cyc[1] - rd_cyc[0], 101);
        if (st_cyc.size() >= 2) check("start_spacing", st_cyc[1] - st_cyc[0], 101);

        // head word scrambled while busy
        scramble = 1;
        push(8'h3C);
        push(8'hC3);
        wait_drain(400);
        scramble = 0;

        // reset during DATA bit 3
        push(8'h5A);
        push(8'h96);
        k = 0;
        while (!(dec_active && dec_cnt >= 44 && dec_cnt <= 46) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) flag_fail("reach_data_bit3");
        n0 = reads;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_read", 32'(fifo_read), 0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_no_extra_pop", reads - n0, 0);
        void'(exp_q.pop_front());
        wait_drain(300);
        check("midrst_next_word_pop", reads - n0, 1);

        // 16 random bytes
        n0 = reads;
        for (int i = 0; i < 16; i++) push(W'($urandom_range(0, 255)));
        wait_drain(16 * 120 + 200);
        check("random_pops", reads - n0, 16);

        check("total_pops", reads, pushed);
        check("exp_q_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
